// File: rtl/imuldiv_muldiv_frontend.sv
// Mul/div request front end: steers requests to the multiplier or divider and
// returns their responses strictly in issue order through a small order queue.
module imuldiv_muldiv_frontend #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,
  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,
  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,
  output logic [1:0]  divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,
  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy,
  output logic [63:0] muldivresp_msg_result,
  output logic        muldivresp_msg_err,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    TGT_MUL = 2'd0,
    TGT_DIV = 2'd1,
    TGT_ERR = 2'd2
  } target_e;

  logic [1:0]    order_mem [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  target_e req_tgt;
  target_e head_tgt;
  logic    full;
  logic    empty;
  logic    unit_rdy;
  logic    push;
  logic    pop;

  always_comb begin
    req_tgt = TGT_ERR;
    if (muldivreq_msg_fn == 3'd0)
      req_tgt = TGT_MUL;
    else if (muldivreq_msg_fn <= 3'd4)
      req_tgt = TGT_DIV;
  end

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign head_tgt = target_e'(order_mem[head_reg]);

  // Illegal functions never wait on a unit, so only the queue limits them.
  always_comb begin
    unit_rdy = 1'b1;
    case (req_tgt)
      TGT_MUL: unit_rdy = mulreq_rdy;
      TGT_DIV: unit_rdy = divreq_rdy;
      default: unit_rdy = 1'b1;
    endcase
  end

  assign muldivreq_rdy = reset && !full && unit_rdy;
  assign mulreq_val    = reset && muldivreq_val && !full && (req_tgt == TGT_MUL);
  assign divreq_val    = reset && muldivreq_val && !full && (req_tgt == TGT_DIV);
  assign mulreq_msg_a  = muldivreq_msg_a;
  assign mulreq_msg_b  = muldivreq_msg_b;
  assign divreq_msg_a  = muldivreq_msg_a;
  assign divreq_msg_b  = muldivreq_msg_b;
  // fn 1..4 map to 0..3; the low two bits minus one wrap 4 onto 3.
  assign divreq_msg_fn = muldivreq_msg_fn[1:0] - 2'd1;

  // Only the unit owning the head entry may hand back a response.
  always_comb begin
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = '0;
    muldivresp_msg_err    = 1'b0;
    mulresp_rdy           = 1'b0;
    divresp_rdy           = 1'b0;
    if (reset && !empty) begin
      case (head_tgt)
        TGT_MUL: begin
          muldivresp_val        = mulresp_val;
          muldivresp_msg_result = mulresp_val ? mulresp_msg_result : '0;
          mulresp_rdy           = muldivresp_rdy;
        end
        TGT_DIV: begin
          muldivresp_val        = divresp_val;
          muldivresp_msg_result = divresp_val ? divresp_msg_result : '0;
          divresp_rdy           = muldivresp_rdy;
        end
        default: begin
          muldivresp_val     = 1'b1;
          muldivresp_msg_err = 1'b1;
        end
      endcase
    end
  end

  assign push = muldivreq_val && muldivreq_rdy;
  assign pop  = muldivresp_val && muldivresp_rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push)
        tail_reg <= tail_reg + 1'b1;
      if (pop)
        head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      order_mem[tail_reg] <= req_tgt;
  end

endmodule

// File: tb/tb_imuldiv_muldiv_frontend.sv
// Bench for the mul/div front end: mock single-slot units with adjustable
// latency, a table of requests and an in-order result scoreboard.
module tb_imuldiv_muldiv_frontend;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [31:0] mulreq_msg_a;
  logic [31:0] mulreq_msg_b;
  logic        mulreq_val;
  logic        mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val;
  logic        mulresp_rdy;
  logic [1:0]  divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_msg_err;
  logic        muldivresp_val;
  logic        muldivresp_rdy;

  imuldiv_muldiv_frontend #(.DEPTH(4), .CW(3)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .mulreq_msg_a          (mulreq_msg_a),
    .mulreq_msg_b          (mulreq_msg_b),
    .mulreq_val            (mulreq_val),
    .mulreq_rdy            (mulreq_rdy),
    .mulresp_msg_result    (mulresp_msg_result),
    .mulresp_val           (mulresp_val),
    .mulresp_rdy           (mulresp_rdy),
    .divreq_msg_fn         (divreq_msg_fn),
    .divreq_msg_a          (divreq_msg_a),
    .divreq_msg_b          (divreq_msg_b),
    .divreq_val            (divreq_val),
    .divreq_rdy            (divreq_rdy),
    .divresp_msg_result    (divresp_msg_result),
    .divresp_val           (divresp_val),
    .divresp_rdy           (divresp_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_msg_err    (muldivresp_msg_err),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy)
  );

  int mul_lat = 2;
  int div_lat = 5;

  function automatic logic [63:0] mul_model(logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa = {{32{a[31]}}, a};
    logic signed [63:0] sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [63:0] div_model(logic [1:0] fn, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa = a;
    logic signed [31:0] sb = b;
    if (!fn[0])
      return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  // Mock multiplier: one operation at a time, response after mul_lat cycles.
  logic        mul_busy;
  int          mul_cnt;
  logic [63:0] mul_res;
  assign mulreq_rdy         = !mul_busy;
  assign mulresp_val        = mul_busy && (mul_cnt == 0);
  assign mulresp_msg_result = mul_res;

  always @(posedge clk) begin
    if (!reset) begin
      mul_busy <= 1'b0;
      mul_cnt  <= 0;
    end else if (!mul_busy) begin
      if (mulreq_val) begin
        mul_busy <= 1'b1;
        mul_cnt  <= mul_lat;
        mul_res  <= mul_model(mulreq_msg_a, mulreq_msg_b);
      end
    end else if (mul_cnt != 0) begin
      mul_cnt <= mul_cnt - 1;
    end else if (mulresp_rdy) begin
      mul_busy <= 1'b0;
    end
  end

  logic        div_busy;
  int          div_cnt;
  logic [63:0] div_res;
  assign divreq_rdy         = !div_busy;
  assign divresp_val        = div_busy && (div_cnt == 0);
  assign divresp_msg_result = div_res;

  always @(posedge clk) begin
    if (!reset) begin
      div_busy <= 1'b0;
      div_cnt  <= 0;
    end else if (!div_busy) begin
      if (divreq_val) begin
        div_busy <= 1'b1;
        div_cnt  <= div_lat;
        div_res  <= div_model(divreq_msg_fn, divreq_msg_a, divreq_msg_b);
      end
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
    end else if (divresp_rdy) begin
      div_busy <= 1'b0;
    end
  end

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [63:0] res;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] cur_res;
  logic        cur_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic tick(output bit fired);
    exp_t e;
    @(negedge clk);
    fired = reset && muldivreq_val && muldivreq_rdy;
    if (fired)
      exp_q.push_back({cur_err, cur_res});
    if (!muldivresp_val) begin
      check("idle_result_zero", {muldivresp_msg_err, muldivresp_msg_result[62:0]}, 64'd0);
    end else if (reset && muldivresp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=%h required=none", muldivresp_msg_result);
      end else begin
        e = exp_q.pop_front();
        check("resp_result", muldivresp_msg_result, e.res);
        check("resp_err", 64'(muldivresp_msg_err), 64'(e.err));
        $display("resp result=%h err=%0b", muldivresp_msg_result, muldivresp_msg_err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic err);
    muldivreq_msg_fn = fn;
    muldivreq_msg_a  = a;
    muldivreq_msg_b  = b;
    cur_res          = res;
    cur_err          = err;
    muldivreq_val    = 1'b1;
  endtask

  task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] res, input logic err);
    bit f;
    int n;
    set_req(fn, a, b, res, err);
    n = 0;
    do begin
      tick(f);
      n++;
    end while (!f && n < 300);
    if (!f)
      fail_now("send_accept");
    else
      $display("req fn=%0d a=%h b=%h", fn, a, b);
    muldivreq_val = 1'b0;
  endtask

  task automatic drain();
    bit f;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      tick(f);
      n++;
    end
    if (exp_q.size() > 0) begin
      fail_now("drain");
      exp_q.delete();
    end
  endtask

  initial begin
    vec_t vecs[12];
    bit   f;
    int   val_cycles;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'd100,      32'd7,         {32'd2, 32'd14},          1'b0};
    vecs[2]  = '{3'd0, 32'd3,        32'd4,         64'd12,                   1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd16,       {32'd15, 32'h0FFF_FFFF},  1'b0};
    vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0};
    vecs[5]  = '{3'd4, 32'd10,       32'd3,         {32'd1, 32'd3},           1'b0};
    vecs[6]  = '{3'd5, 32'd9,        32'd9,         64'd0,                    1'b1};
    vecs[7]  = '{3'd1, 32'hFFFF_FFEC, 32'd6,        {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 1'b0};
    vecs[8]  = '{3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'd30,                  1'b0};
    vecs[9]  = '{3'd7, 32'd1,        32'd2,         64'd0,                    1'b1};
    vecs[10] = '{3'd0, 32'h8000_0000, 32'd2,        64'hFFFF_FFFF_0000_0000,  1'b0};
    vecs[11] = '{3'd2, 32'd1000,     32'd10,        {32'd0, 32'd100},         1'b0};

    reset            = 1'b0;
    muldivreq_msg_fn = 3'd0;
    muldivreq_msg_a  = '0;
    muldivreq_msg_b  = '0;
    muldivreq_val    = 1'b0;
    muldivresp_rdy   = 1'b1;
    cur_res          = '0;
    cur_err          = 1'b0;

    // Reset held two cycles; every handshake output stays low meanwhile.
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_req_rdy", 64'(muldivreq_rdy), 64'd0);
    check("rst_resp_val", 64'(muldivresp_val), 64'd0);
    check("rst_mulresp_rdy", 64'(mulresp_rdy), 64'd0);
    check("rst_divresp_rdy", 64'(divresp_rdy), 64'd0);
    reset = 1'b1;
    #1;
    check("rel_req_rdy", 64'(muldivreq_rdy), 64'd1);
    check("rel_resp_val", 64'(muldivresp_val), 64'd0);
    check("rel_mulreq_val", 64'(mulreq_val), 64'd0);
    check("rel_divreq_val", 64'(divreq_val), 64'd0);

    // Slow multiplier, single request.
    mul_lat = 33;
    set_req(3'd0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    #1;
    check("mul_req_val", 64'(mulreq_val), 64'd1);
    tick(f);
    check("mul_accept", 64'(f), 64'd1);
    muldivreq_val = 1'b0;
    #1;
    check("mul_req_val_drop", 64'(mulreq_val), 64'd0);
    drain();

    // Fast MUL behind slow DIV must wait in its unit.
    div_lat = 40;
    mul_lat = 2;
    send(3'd1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    send(3'd0, 32'd3, 32'd4, 64'd12, 1'b0);
    repeat (6) tick(f);
    check("ooo_mulresp_val", 64'(mulresp_val), 64'd1);
    check("ooo_mulresp_rdy", 64'(mulresp_rdy), 64'd0);
    check("ooo_resp_val", 64'(muldivresp_val), 64'd0);
    drain();

    // Table of mixed requests, back to back.
    mul_lat = 3;
    div_lat = 6;
    for (int i = 0; i < 12; i++)
      send(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);
    drain();

    // Full queue: a fifth request is refused even with a same-cycle pop.
    muldivresp_rdy = 1'b0;
    send(3'd5, 32'd0, 32'd0, 64'd0, 1'b1);
    send(3'd6, 32'd0, 32'd0, 64'd0, 1'b1);
    send(3'd7, 32'd0, 32'd0, 64'd0, 1'b1);
    send(3'd5, 32'd0, 32'd0, 64'd0, 1'b1);
    set_req(3'd1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    #1;
    check("full_req_rdy", 64'(muldivreq_rdy), 64'd0);
    check("full_divreq_val", 64'(divreq_val), 64'd0);
    check("full_mulreq_val", 64'(mulreq_val), 64'd0);
    tick(f);
    check("full_hold_accept", 64'(f), 64'd0);
    muldivresp_rdy = 1'b1;
    tick(f);
    check("full_pop_push_refused", 64'(f), 64'd0);
    muldivresp_rdy = 1'b0;
    tick(f);
    check("full_next_accept", 64'(f), 64'd1);
    muldivreq_val  = 1'b0;
    muldivresp_rdy = 1'b1;
    drain();

    // Illegal function: answers the cycle after acceptance and holds under stall.
    set_req(3'd6, 32'd1, 32'd1, 64'd0, 1'b1);
    #1;
    check("err_no_mulreq", 64'(mulreq_val), 64'd0);
    check("err_no_divreq", 64'(divreq_val), 64'd0);
    check("err_not_early", 64'(muldivresp_val), 64'd0);
    tick(f);
    check("err_accept", 64'(f), 64'd1);
    muldivreq_val  = 1'b0;
    muldivresp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("err_hold_val", 64'(muldivresp_val), 64'd1);
      check("err_hold_flag", 64'(muldivresp_msg_err), 64'd1);
      check("err_hold_result", muldivresp_msg_result, 64'd0);
      tick(f);
    end
    muldivresp_rdy = 1'b1;
    drain();

    // Reset with work in flight: nothing stale may come back.
    div_lat = 20;
    mul_lat = 20;
    send(3'd1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    send(3'd0, 32'd3, 32'd4, 64'd12, 1'b0);
    repeat (3) tick(f);
    reset = 1'b0;
    exp_q.delete();
    tick(f);
    reset = 1'b1;
    #1;
    check("midrst_resp_val", 64'(muldivresp_val), 64'd0);
    check("midrst_req_rdy", 64'(muldivreq_rdy), 64'd1);
    val_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (muldivresp_val)
        val_cycles++;
      tick(f);
    end
    check("midrst_no_stale", 64'(val_cycles), 64'd0);
    div_lat = 4;
    send(3'd4, 32'd10, 32'd3, {32'd1, 32'd3}, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
